acq_sequencer: RTL and testbench
================================

// Module: acq_sequencer
// PURPOSE
//   Run controller for the time-tagger datapath. It sequences one acquisition:
//   pulse the timer clear, hold operate for the run, then drain the timer pipeline.
//   Records from the timer (data_rdy/data, no backpressure) pass through a
//   one-entry valid/ready buffer to the downstream FIFO/host link; records that
//   cannot be stored are counted as lost. Sits between the host register file and
//   the timer/latch datapath.
// PARAMETERS
//   REC_W        47  record width (timer data bus)
//   CNT_W        32  record-count / limit / duration width
//   LOST_W       16  lost-record counter width (saturating)
//   CLEAR_CYCLES 4   cycles reset_counter is held high in CLEAR (>=1)
//   DRAIN_CYCLES 8   cycles spent in DRAIN before return to IDLE (>=1)
// PORTS
//   clk           in   1       system clock
//   reset         in   1       synchronous, active-high reset
//   start         in   1       1-cycle pulse: begin acquisition (honoured only in IDLE)
//   stop          in   1       1-cycle pulse: end acquisition
//   max_records   in   CNT_W   auto-stop after this many records; 0 = unlimited
//   duration      in   CNT_W   RUN length in clk cycles; 0 = unlimited (ACQSEQ_DURATION_EN only)
//   operate       out  1       to timer/latches: acquisition enable
//   reset_counter out  1       to timer: clear timestamp counter
//   rec_rdy       in   1       timer data_rdy
//   rec_data      in   REC_W   timer data
//   out_valid     out  1       buffered record valid
//   out_data      out  REC_W   buffered record
//   out_ready     in   1       downstream accepts out_data
//   busy          out  1       state != IDLE
//   state_o       out  2       IDLE=0 CLEAR=1 RUN=2 DRAIN=3
//   record_count  out  CNT_W   records accepted this run
//   lost_count    out  LOST_W  records dropped on a full buffer (saturates at all-ones)
//   overflow      out  1       sticky: lost_count != 0
// BEHAVIOUR
//   Reset: state IDLE. All outputs 0: operate, reset_counter, out_valid, out_data,
//     counters, overflow. The buffer is emptied. Reset mid-run aborts immediately.
//   IDLE: operate=0, reset_counter=0. On start & !stop: clear record_count, lost_count
//     and overflow, then go to CLEAR. start & stop in the same cycle leaves the block in IDLE.
//   CLEAR: reset_counter=1 and operate=0 for exactly CLEAR_CYCLES cycles, then RUN.
//     stop in CLEAR returns to IDLE.
//   RUN: operate=1. Go to DRAIN on any of:
//     - stop;
//     - an accepted record that makes record_count == max_records (max_records != 0);
//     - duration expiry (macro only).
//     operate drops in the first DRAIN cycle. start is ignored outside IDLE.
//   DRAIN: operate=0. Stay DRAIN_CYCLES cycles and until the buffer is empty, then IDLE.
//   Record acceptance: rec_rdy is honoured only in RUN and DRAIN. In IDLE and CLEAR it
//     is ignored and not counted as lost. Once record_count == max_records (max_records != 0),
//     further records are discarded silently and not counted as lost.
//   Buffer: one entry. rec_rdy at cycle n -> out_valid=1 at n+1. out_data holds stable
//     while out_valid & !out_ready. Transfer occurs on out_valid & out_ready.
//     rec_rdy in the same cycle as a transfer loads the new record with no loss.
//     rec_rdy while out_valid & !out_ready drops the record: lost_count += 1
//     (saturating) and overflow is set.
//   record_count increments once per record loaded into the buffer; it never wraps
//     (the limit is checked first).
// CONFIGURATION
//   `ACQSEQ_DURATION_EN defined: duration port present. A cycle counter is cleared on
//     CLEAR->RUN and increments each RUN cycle. When it reaches duration (duration != 0),
//     the next state is DRAIN, so RUN lasts exactly duration cycles.
//   Undefined: no duration port and no counter; RUN ends only on stop or the record limit.
// STRUCTURE
//   acqseq_pkg (shared include): state encodings ST_IDLE..ST_DRAIN, REC_W default,
//     state_o width.
//   Sub-module acq_rec_buffer: one-entry valid/ready register with drop detection and
//     the saturating lost_count. The top level holds the FSM, timers and record_count.
// TESTING
//   1 Start, max_records=0: reset_counter high cycles 1..4, operate high from cycle 5;
//     stop at 100 -> operate low at 101; IDLE after 8 DRAIN cycles.
//   2 max_records=3, out_ready=1, 5 rec_rdy pulses 2 cycles apart -> 3 transfers,
//     record_count=3, DRAIN entered the cycle after the 3rd accept, lost_count=0.
//   3 out_ready=0, rec_rdy on 3 consecutive cycles -> the first record is held stable;
//     lost_count=2, overflow=1. Then out_ready=1 -> exactly one transfer.
//   4 rec_rdy and a transfer in the same cycle -> both records delivered in order,
//     no loss. rec_rdy in IDLE/CLEAR -> out_valid stays 0, no count change.
//   5 reset asserted in RUN with out_valid=1 -> next cycle: IDLE, all outputs 0.
//     start & stop together in IDLE -> stays IDLE.
//   6 (ACQSEQ_DURATION_EN) duration=10 -> operate high exactly 10 cycles. duration=0
//     -> runs until stop. lost_count saturation checked with LOST_W=2.

Source files
------------

// File: rtl/acqseq_pkg.sv
// Shared definitions for the acquisition sequencer: state encoding and default widths.
package acqseq_pkg;

   localparam int REC_W_DEF = 47;
   localparam int STATE_W   = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } acq_state_t;

endpackage

// File: rtl/acq_sequencer_rec_buffer.sv
// One-entry valid/ready record buffer with drop detection and a saturating lost counter.
module acq_rec_buffer
   import acqseq_pkg::*;
#(
   parameter int REC_W  = REC_W_DEF,
   parameter int LOST_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              accept,
   input  logic [REC_W-1:0]  rec_data,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [REC_W-1:0]  out_data,
   output logic              loaded,
   output logic [LOST_W-1:0] lost_count,
   output logic              overflow
);

   logic drop;

   // A record loads when the slot is empty or is being emptied this cycle; otherwise it is dropped.
   always_comb begin
      loaded = accept && (!out_valid || out_ready);
      drop   = accept && out_valid && !out_ready;
   end

   // Buffer slot, lost counter (saturating) and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         lost_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (loaded) begin
            out_valid <= 1'b1;
            out_data  <= rec_data;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (clear) begin
            lost_count <= '0;
            overflow   <= 1'b0;
         end else if (drop) begin
            if (lost_count != '1) lost_count <= lost_count + LOST_W'(1);
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition run controller: CLEAR -> RUN -> DRAIN sequencing, record limit and buffering.
// Optional macro ACQSEQ_DURATION_EN adds the duration port and a RUN-length timer.
module acq_sequencer
   import acqseq_pkg::*;
#(
   parameter int REC_W        = REC_W_DEF,
   parameter int CNT_W        = 32,
   parameter int LOST_W       = 16,
   parameter int CLEAR_CYCLES = 4,
   parameter int DRAIN_CYCLES = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic [CNT_W-1:0]   max_records,
`ifdef ACQSEQ_DURATION_EN
   input  logic [CNT_W-1:0]   duration,
`endif
   output logic               operate,
   output logic               reset_counter,
   input  logic               rec_rdy,
   input  logic [REC_W-1:0]   rec_data,
   output logic               out_valid,
   output logic [REC_W-1:0]   out_data,
   input  logic               out_ready,
   output logic               busy,
   output logic [STATE_W-1:0] state_o,
   output logic [CNT_W-1:0]   record_count,
   output logic [LOST_W-1:0]  lost_count,
   output logic               overflow
);

   localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
   localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
   localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

   acq_state_t       state;
   logic [CLR_W-1:0] clr_cnt;
   logic [DRN_W-1:0] drn_cnt;
`ifdef ACQSEQ_DURATION_EN
   logic [CNT_W-1:0] dur_cnt;
`endif

   logic in_acq, at_limit, accept, loaded, begin_run;
   logic limit_end, dur_end, run_end, buf_empty_next;

   // Acceptance, run-termination and drain-exit conditions.
   always_comb begin
      in_acq    = (state == ST_RUN) || (state == ST_DRAIN);
      at_limit  = (max_records != '0) && (record_count == max_records);
      accept    = in_acq && rec_rdy && !at_limit && (record_count != '1);
      begin_run = (state == ST_IDLE) && start && !stop;
      limit_end = loaded && (max_records != '0) &&
                  ((record_count + CNT_W'(1)) == max_records);
`ifdef ACQSEQ_DURATION_EN
      dur_end   = (duration != '0) && (dur_cnt == (duration - CNT_W'(1)));
`else
      dur_end   = 1'b0;
`endif
      run_end        = stop || limit_end || dur_end;
      buf_empty_next = !loaded && (!out_valid || out_ready);
   end

   // Sequencer FSM with registered operate/reset_counter, phase timers and record count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         operate       <= 1'b0;
         reset_counter <= 1'b0;
         clr_cnt       <= '0;
         drn_cnt       <= '0;
         record_count  <= '0;
`ifdef ACQSEQ_DURATION_EN
         dur_cnt       <= '0;
`endif
      end else begin
         if (begin_run)   record_count <= '0;
         else if (loaded) record_count <= record_count + CNT_W'(1);

         case (state)
            ST_IDLE: begin
               if (begin_run) begin
                  state         <= ST_CLEAR;
                  reset_counter <= 1'b1;
                  clr_cnt       <= '0;
               end
            end
            ST_CLEAR: begin
               if (stop) begin
                  state         <= ST_IDLE;
                  reset_counter <= 1'b0;
               end else if (clr_cnt == CLR_LAST) begin
                  state         <= ST_RUN;
                  reset_counter <= 1'b0;
                  operate       <= 1'b1;
`ifdef ACQSEQ_DURATION_EN
                  dur_cnt       <= '0;
`endif
               end else begin
                  clr_cnt <= clr_cnt + CLR_W'(1);
               end
            end
            ST_RUN: begin
`ifdef ACQSEQ_DURATION_EN
               dur_cnt <= dur_cnt + CNT_W'(1);
`endif
               if (run_end) begin
                  state   <= ST_DRAIN;
                  operate <= 1'b0;
                  drn_cnt <= '0;
               end
            end
            ST_DRAIN: begin
               // Minimum dwell first, then wait for the buffer to empty.
               if (drn_cnt != DRN_LAST)  drn_cnt <= drn_cnt + DRN_W'(1);
               else if (buf_empty_next) state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy    = (state != ST_IDLE);
   assign state_o = state;

   acq_rec_buffer #(
      .REC_W  (REC_W),
      .LOST_W (LOST_W)
   ) u_buf (
      .clk        (clk),
      .reset      (reset),
      .clear      (begin_run),
      .accept     (accept),
      .rec_data   (rec_data),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .loaded     (loaded),
      .lost_count (lost_count),
      .overflow   (overflow)
   );

endmodule

// File: tb/tb_acq_sequencer.sv
// Testbench for acq_sequencer: directed steps plus randomized runs against a behavioural model.
module tb_acq_sequencer;

   localparam int REC_W    = 47;
   localparam int CNT_W    = 32;
   localparam int LOST_W   = 2;
   localparam int CLR_N    = 4;
   localparam int DRN_N    = 8;
   localparam int LOST_MAX = (1 << LOST_W) - 1;

   logic               clk = 1'b0;
   logic               reset, start, stop, rec_rdy, out_ready;
   logic [CNT_W-1:0]   max_records;
`ifdef ACQSEQ_DURATION_EN
   logic [CNT_W-1:0]   duration;
`endif
   logic [REC_W-1:0]   rec_data;
   logic               operate, reset_counter, out_valid, busy, overflow;
   logic [REC_W-1:0]   out_data;
   logic [1:0]         state_o;
   logic [CNT_W-1:0]   record_count;
   logic [LOST_W-1:0]  lost_count;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: phase (0 idle,1 clear,2 run,3 drain), cycles spent in phase, buffer queue.
   int unsigned      m_phase, m_age, m_count, m_lost;
   bit               m_ovf;
   logic [REC_W-1:0] m_q[$];

   // Observed deliveries.
   int               xfer_cnt;
   logic [REC_W-1:0] got_q[$];

   acq_sequencer #(
      .REC_W        (REC_W),
      .CNT_W        (CNT_W),
      .LOST_W       (LOST_W),
      .CLEAR_CYCLES (CLR_N),
      .DRAIN_CYCLES (DRN_N)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .stop          (stop),
      .max_records   (max_records),
`ifdef ACQSEQ_DURATION_EN
      .duration      (duration),
`endif
      .operate       (operate),
      .reset_counter (reset_counter),
      .rec_rdy       (rec_rdy),
      .rec_data      (rec_data),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_ready     (out_ready),
      .busy          (busy),
      .state_o       (state_o),
      .record_count  (record_count),
      .lost_count    (lost_count),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      bit accepting, stored, dur_hit;
      if (reset) begin
         m_phase = 0; m_age = 0; m_count = 0; m_lost = 0; m_ovf = 0;
         m_q.delete();
         return;
      end
      accepting = (m_phase == 2 || m_phase == 3) && rec_rdy &&
                  !(max_records != 0 && m_count == max_records);
      if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
      stored = 0;
      if (accepting) begin
         if (m_q.size() == 0) begin
            m_q.push_back(rec_data);
            m_count++;
            stored = 1;
         end else begin
            if (m_lost < LOST_MAX) m_lost++;
            m_ovf = 1;
         end
      end
      dur_hit = 0;
`ifdef ACQSEQ_DURATION_EN
      dur_hit = (duration != 0) && (m_age + 1 == duration);
`endif
      case (m_phase)
         0: if (start && !stop) begin
               m_phase = 1; m_age = 0; m_count = 0; m_lost = 0; m_ovf = 0;
            end
         1: if (stop) m_phase = 0;
            else if (m_age == CLR_N - 1) begin m_phase = 2; m_age = 0; end
            else m_age++;
         2: if (stop || (stored && max_records != 0 && m_count == max_records) || dur_hit) begin
               m_phase = 3; m_age = 0;
            end else m_age++;
         default: if (m_age >= DRN_N - 1 && m_q.size() == 0) m_phase = 0;
                  else m_age++;
      endcase
   endtask

   task automatic check_outputs();
      chk("state_o", state_o, m_phase);
      chk("operate", operate, m_phase == 2);
      chk("reset_counter", reset_counter, m_phase == 1);
      chk("busy", busy, m_phase != 0);
      chk("out_valid", out_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
      chk("record_count", record_count, m_count);
      chk("lost_count", lost_count, m_lost);
      chk("overflow", overflow, m_ovf);
   endtask

   task automatic tick();
      if (out_valid && out_ready) begin
         xfer_cnt++;
         got_q.push_back(out_data);
      end
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic start_run();
      int n;
      start = 1; tick(); start = 0;
      n = 0;
      while (state_o != 2'd2 && n < 12) begin n++; tick(); end
      chk("reach_run", state_o, 2);
   endtask

   task automatic finish_run();
      int n;
      stop = 1; tick(); stop = 0;
      rec_rdy = 0; out_ready = 1;
      n = 0;
      while (state_o != 2'd0 && n < 40) begin n++; tick(); end
      chk("reach_idle", state_o, 0);
   endtask

   function automatic logic [REC_W-1:0] rnd_rec();
      return {$urandom, $urandom};
   endfunction

   initial begin
      int op, rc, n;
      logic [REC_W-1:0] d0, d1, d2;
      logic [REC_W-1:0] sent_q[$];

      reset = 1; start = 0; stop = 0; rec_rdy = 0; out_ready = 0;
      max_records = '0; rec_data = '0;
`ifdef ACQSEQ_DURATION_EN
      duration = '0;
`endif
      xfer_cnt = 0;
      tick(); tick();
      chk("rst_out_data", out_data, 0);
      reset = 0;
      tick();

      // Basic sequencing: 4 clear cycles, run until stop, 8 drain cycles.
      start = 1; tick(); start = 0;
      op = 0; rc = 0;
      for (int c = 1; c <= 100; c++) begin
         op += int'(operate);
         rc += int'(reset_counter);
         if (c == 100) stop = 1;
         tick();
      end
      stop = 0;
      chk("t1_operate_low", operate, 0);
      n = 0;
      while (state_o == 2'd3 && n < 40) begin n++; tick(); end
      chk("t1_drain_len", n, DRN_N);
      chk("t1_operate_cycles", op, 96);
      chk("t1_reset_counter_cycles", rc, CLR_N);

      // Record limit of 3 with five pulses.
      max_records = 3; xfer_cnt = 0;
      start_run();
      out_ready = 1;
      for (int p = 0; p < 5; p++) begin
         rec_data = rnd_rec(); rec_rdy = 1; tick(); rec_rdy = 0;
         if (p == 2) chk("t2_drain_after_limit", state_o, 3);
         tick();
      end
      finish_run();
      chk("t2_transfers", xfer_cnt, 3);
      chk("t2_record_count", record_count, 3);
      chk("t2_lost", lost_count, 0);

      // Full buffer: hold first record, drop the next two, then saturate.
      max_records = 0;
      start_run();
      out_ready = 0;
      d0 = rnd_rec(); d1 = rnd_rec(); d2 = rnd_rec();
      rec_rdy = 1;
      rec_data = d0; tick();
      rec_data = d1; tick();
      rec_data = d2; tick();
      rec_rdy = 0;
      chk("t3_held_data", out_data, d0);
      chk("t3_lost", lost_count, 2);
      chk("t3_overflow", overflow, 1);
      xfer_cnt = 0; out_ready = 1;
      tick(); tick(); tick();
      chk("t3_one_transfer", xfer_cnt, 1);
      out_ready = 0; rec_rdy = 1;
      for (int i = 0; i < 6; i++) begin rec_data = rnd_rec(); tick(); end
      rec_rdy = 0;
      chk("t3_lost_saturated", lost_count, LOST_MAX);
      finish_run();

      // Records in IDLE/CLEAR ignored; back-to-back load-with-transfer loses nothing.
      rec_rdy = 1; rec_data = rnd_rec();
      tick(); tick();
      start = 1; tick(); start = 0;
      n = 0;
      while (state_o != 2'd2 && n < 12) begin n++; tick(); end
      chk("t4_clear_ignored_valid", out_valid, 0);
      chk("t4_clear_ignored_count", record_count, 0);
      chk("t4_clear_ignored_lost", lost_count, 0);
      out_ready = 1; got_q.delete(); sent_q.delete();
      for (int i = 0; i < 6; i++) begin
         rec_data = rnd_rec(); sent_q.push_back(rec_data); tick();
      end
      rec_rdy = 0;
      tick(); tick();
      chk("t4_delivered", got_q.size(), 6);
      for (int i = 0; i < 6 && i < got_q.size(); i++) chk("t4_order", got_q[i], sent_q[i]);
      chk("t4_lost", lost_count, 0);
      finish_run();

      // Randomized runs against the model.
      for (int r = 0; r < 6; r++) begin
         max_records = $urandom_range(0, 4);
         start_run();
         for (int c = 0; c < 40; c++) begin
            rec_rdy   = $urandom_range(0, 1) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            rec_data  = rnd_rec();
            stop      = $urandom_range(0, 63) == 0;
            tick();
         end
         finish_run();
      end

      // Reset mid-run with a record in the buffer; start & stop together.
      max_records = 0;
      start_run();
      out_ready = 0; rec_rdy = 1; rec_data = rnd_rec(); tick(); rec_rdy = 0;
      chk("t5_valid_before_reset", out_valid, 1);
      reset = 1; tick(); reset = 0;
      chk("t5_state", state_o, 0);
      chk("t5_operate", operate, 0);
      chk("t5_out_valid", out_valid, 0);
      chk("t5_out_data", out_data, 0);
      chk("t5_record_count", record_count, 0);
      chk("t5_overflow", overflow, 0);
      start = 1; stop = 1; tick(); start = 0; stop = 0;
      chk("t5_start_stop_idle", state_o, 0);
      tick();
      chk("t5_still_idle", busy, 0);

`ifdef ACQSEQ_DURATION_EN
      // Duration-limited run and unlimited duration.
      duration = 10; out_ready = 1;
      start_run();
      op = 0;
      for (int c = 0; c < 30; c++) begin op += int'(operate); tick(); end
      chk("t6_duration_cycles", op, 10);
      finish_run();
      duration = 0;
      start_run();
      for (int c = 0; c < 50; c++) tick();
      chk("t6_unlimited_running", state_o, 2);
      finish_run();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
